xc_malu_issue: RTL and testbench

- Initiator-side sequencer for the xc_malu valid/ready/flush interface.
- Accepts one decoded multi-cycle ALU request from the pipeline and drives xc_malu with stable operands and control until it reports ready.
- Captures the 64-bit result and presents it to writeback under a valid/ready handshake.
- Replaces the ad-hoc valid/flush driving that each core integration currently does.

---
 rtl/xc_malu_pkg.sv | 39 +++
 rtl/xc_malu_issue_decode.sv | 47 ++++
 rtl/xc_malu_issue.sv | 228 ++++++++++++++++++++++
 tb/tb_xc_malu_issue.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xc_malu_pkg.sv
// xc_malu_pkg: shared definitions for the xc_malu issue sequencer.
//   - request class encodings (CLS_MUL .. CLS_RSV)
//   - pack-width index constants used by the pmul class
//   - FSM state encoding of the issue sequencer
package xc_malu_pkg;

    // Request class encoding as delivered by the decoder.
    localparam logic [2:0] CLS_MUL  = 3'd0;
    localparam logic [2:0] CLS_PMUL = 3'd1;
    localparam logic [2:0] CLS_DIV  = 3'd2;
    localparam logic [2:0] CLS_REM  = 3'd3;
    localparam logic [2:0] CLS_MACC = 3'd4;
    localparam logic [2:0] CLS_MADD = 3'd5;
    localparam logic [2:0] CLS_MSUB = 3'd6;
    localparam logic [2:0] CLS_RSV  = 3'd7;

    // Number of real (one-hot) instruction lines towards the malu.
    localparam int N_INSN = 7;

    // Pack-width select indices; anything above PW_IDX_MAX is illegal.
    localparam logic [2:0] PW_IDX_0   = 3'd0;
    localparam logic [2:0] PW_IDX_1   = 3'd1;
    localparam logic [2:0] PW_IDX_2   = 3'd2;
    localparam logic [2:0] PW_IDX_3   = 3'd3;
    localparam logic [2:0] PW_IDX_4   = 3'd4;
    localparam logic [2:0] PW_IDX_MAX = PW_IDX_4;

    // Pack width presented for every class other than pmul.
    localparam logic [4:0] PW_DEFAULT = 5'b00001;

    // Issue sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FLSH = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/xc_malu_issue_decode.sv
// xc_malu_issue_decode: combinational request decode for the malu.
// Ports:
//   cls        in   request class (CLS_*)
//   pw         in   pack-width select, only meaningful for pmul
//   clmul      in   carryless request flag
//   insn       out  one-hot instruction lines, bit index == class
//   pw_onehot  out  malu pack-width vector
//   carryless  out  carryless qualified by class (mul/pmul only)
//   err        out  reserved class, or pmul with an out-of-range pw
module xc_malu_issue_decode
    import xc_malu_pkg::*;
(
    input  logic [2:0]        cls,
    input  logic [2:0]        pw,
    input  logic              clmul,
    output logic [N_INSN-1:0] insn,
    output logic [4:0]        pw_onehot,
    output logic              carryless,
    output logic              err
);

    // The reserved class shifts into bit 7, which is dropped, so it
    // naturally decodes to no instruction line at all.
    logic [7:0] cls_onehot;

    always_comb begin
        cls_onehot = 8'b1 << cls;
        insn       = cls_onehot[N_INSN-1:0];

        pw_onehot = PW_DEFAULT;
        if (cls == CLS_PMUL) begin
            // MSB-first: pw 0 selects bit 4, pw 4 selects bit 0.
            case (pw)
                PW_IDX_0: pw_onehot = 5'b10000;
                PW_IDX_1: pw_onehot = 5'b01000;
                PW_IDX_2: pw_onehot = 5'b00100;
                PW_IDX_3: pw_onehot = 5'b00010;
                PW_IDX_4: pw_onehot = 5'b00001;
                default:  pw_onehot = 5'b00000;
            endcase
        end

        carryless = clmul && ((cls == CLS_MUL) || (cls == CLS_PMUL));
        err       = (cls == CLS_RSV) || ((cls == CLS_PMUL) && (pw > PW_IDX_MAX));
    end

endmodule

// File: rtl/xc_malu_issue.sv
// xc_malu_issue: initiator-side sequencer for the xc_malu valid/ready/flush
// interface. Takes one decoded request, holds operands/control stable on the
// malu until it reports ready, then offers the 64-bit result to writeback.
// Ports:
//   clock, resetn          clock, synchronous active-low reset
//   kill                   pipeline flush, abandons in-flight or held request
//   req_*                  request channel (valid/ready) with class,
//                          modifiers, operands and destination tag
//   malu_*  (outputs)      registered operands/control, valid and flush
//   malu_ready, malu_result_1/0   malu completion and result
//   rsp_*                  response channel (valid/ready) with tag, result,
//                          error flag and saturating RUN-cycle count
//   dbg_state              current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. rsp_valid, once high, stays high with stable payload until
// rsp_ready or kill. req_ready depends on kill and rsp_ready combinationally.
module xc_malu_issue
    import xc_malu_pkg::*;
#(
    parameter int CYCLE_W = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               kill,

    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_class,
    input  logic [2:0]         req_pw,
    input  logic               req_lhs_sign,
    input  logic               req_rhs_sign,
    input  logic               req_unsigned,
    input  logic               req_clmul,
    input  logic [31:0]        req_rs1,
    input  logic [31:0]        req_rs2,
    input  logic [31:0]        req_rs3,
    input  logic [4:0]         req_rd,

    output logic [31:0]        malu_rs1,
    output logic [31:0]        malu_rs2,
    output logic [31:0]        malu_rs3,
    output logic               malu_valid,
    output logic               malu_flush,
    input  logic               malu_ready,
    output logic               malu_insn_mul,
    output logic               malu_insn_pmul,
    output logic               malu_insn_div,
    output logic               malu_insn_rem,
    output logic               malu_insn_macc,
    output logic               malu_insn_madd,
    output logic               malu_insn_msub,
    output logic [4:0]         malu_pw,
    output logic               malu_lhs_sign,
    output logic               malu_rhs_sign,
    output logic               malu_drem_unsigned,
    output logic               malu_carryless,
    input  logic [31:0]        malu_result_1,
    input  logic [31:0]        malu_result_0,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [4:0]         rsp_rd,
    output logic [31:0]        rsp_hi,
    output logic [31:0]        rsp_lo,
    output logic               rsp_err,
    output logic [CYCLE_W-1:0] rsp_cycles,

    output state_t             dbg_state
);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [N_INSN-1:0] insn_q;

    logic [N_INSN-1:0] dec_insn;
    logic [4:0]        dec_pw;
    logic              dec_carryless;
    logic              dec_err;

    // Decode the live request; results are latched only on accept.
    xc_malu_issue_decode u_decode (
        .cls       (req_class),
        .pw        (req_pw),
        .clmul     (req_clmul),
        .insn      (dec_insn),
        .pw_onehot (dec_pw),
        .carryless (dec_carryless),
        .err       (dec_err)
    );

    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

    assign malu_insn_mul  = insn_q[CLS_MUL];
    assign malu_insn_pmul = insn_q[CLS_PMUL];
    assign malu_insn_div  = insn_q[CLS_DIV];
    assign malu_insn_rem  = insn_q[CLS_REM];
    assign malu_insn_macc = insn_q[CLS_MACC];
    assign malu_insn_madd = insn_q[CLS_MADD];
    assign malu_insn_msub = insn_q[CLS_MSUB];

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Illegal requests bypass the malu entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = dec_err ? ST_HOLD : ST_RUN;
                end
            end
            ST_RUN: begin
                if (kill) begin
                    state_nxt = ST_FLSH;
                end else if (malu_ready) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_FLSH: begin
                state_nxt = ST_IDLE;
            end
            ST_HOLD: begin
                if (kill) begin
                    state_nxt = ST_IDLE;
                end else if (rsp_ready) begin
                    if (accept) begin
                        state_nxt = dec_err ? ST_HOLD : ST_RUN;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and malu strobes. Everything is forced low while in reset
    // so a mid-operation reset never emits a flush.
    always_comb begin
        req_ready  = 1'b0;
        malu_valid = 1'b0;
        malu_flush = 1'b0;
        rsp_valid  = 1'b0;
        if (resetn) begin
            case (state)
                ST_IDLE: begin
                    req_ready = !kill;
                end
                ST_RUN: begin
                    // kill wins over completion: valid drops, flush still fires.
                    malu_valid = !kill;
                    malu_flush = kill || malu_ready;
                end
                ST_FLSH: begin
                    malu_flush = 1'b1;
                end
                ST_HOLD: begin
                    rsp_valid = 1'b1;
                    req_ready = rsp_ready && !kill;
                end
                default: begin
                    req_ready = 1'b0;
                end
            endcase
        end
    end

    // Request latch, RUN-cycle counter and response capture.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            malu_rs1           <= '0;
            malu_rs2           <= '0;
            malu_rs3           <= '0;
            insn_q             <= '0;
            malu_pw            <= '0;
            malu_lhs_sign      <= 1'b0;
            malu_rhs_sign      <= 1'b0;
            malu_drem_unsigned <= 1'b0;
            malu_carryless     <= 1'b0;
            rsp_rd             <= '0;
            rsp_hi             <= '0;
            rsp_lo             <= '0;
            rsp_err            <= 1'b0;
            rsp_cycles         <= '0;
        end else begin
            if (accept) begin
                rsp_rd     <= req_rd;
                rsp_cycles <= '0;
                if (dec_err) begin
                    // The malu-facing registers keep their old values.
                    rsp_err <= 1'b1;
                    rsp_hi  <= '0;
                    rsp_lo  <= '0;
                end else begin
                    rsp_err            <= 1'b0;
                    malu_rs1           <= req_rs1;
                    malu_rs2           <= req_rs2;
                    malu_rs3           <= req_rs3;
                    insn_q             <= dec_insn;
                    malu_pw            <= dec_pw;
                    malu_lhs_sign      <= req_lhs_sign;
                    malu_rhs_sign      <= req_rhs_sign;
                    malu_drem_unsigned <= req_unsigned;
                    malu_carryless     <= dec_carryless;
                end
            end else if (state == ST_RUN) begin
                if (rsp_cycles != '1) begin
                    rsp_cycles <= rsp_cycles + CYCLE_W'(1);
                end
                if (malu_ready && !kill) begin
                    rsp_hi <= malu_result_1;
                    rsp_lo <= malu_result_0;
                end
            end
        end
    end

endmodule

// File: tb/tb_xc_malu_issue.sv
// tb_xc_malu_issue: self-checking bench for xc_malu_issue. The bench plays
// both the pipeline and the malu; expected responses come from a behavioural
// arithmetic model applied to the original request fields.
module tb_xc_malu_issue;
  import xc_malu_pkg::*;

  localparam int CYCLE_W = 8;
  localparam int W = 1 + 5 + 64;  // {err, rd, hi, lo}

  logic clock, resetn, kill;
  logic req_valid, req_ready;
  logic [2:0] req_class, req_pw;
  logic req_lhs_sign, req_rhs_sign, req_unsigned, req_clmul;
  logic [31:0] req_rs1, req_rs2, req_rs3;
  logic [4:0] req_rd;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3;
  logic malu_valid, malu_flush, malu_ready;
  logic malu_insn_mul, malu_insn_pmul, malu_insn_div, malu_insn_rem;
  logic malu_insn_macc, malu_insn_madd, malu_insn_msub;
  logic [4:0] malu_pw;
  logic malu_lhs_sign, malu_rhs_sign, malu_drem_unsigned, malu_carryless;
  logic [31:0] malu_result_1, malu_result_0;
  logic rsp_valid, rsp_ready;
  logic [4:0] rsp_rd;
  logic [31:0] rsp_hi, rsp_lo;
  logic rsp_err;
  logic [CYCLE_W-1:0] rsp_cycles;
  state_t dbg_state;

  xc_malu_issue #(.CYCLE_W(CYCLE_W)) dut (
    .clock(clock), .resetn(resetn), .kill(kill),
    .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class), .req_pw(req_pw),
    .req_lhs_sign(req_lhs_sign), .req_rhs_sign(req_rhs_sign), .req_unsigned(req_unsigned),
    .req_clmul(req_clmul), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_rd(req_rd),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_valid(malu_valid), .malu_flush(malu_flush), .malu_ready(malu_ready),
    .malu_insn_mul(malu_insn_mul), .malu_insn_pmul(malu_insn_pmul), .malu_insn_div(malu_insn_div),
    .malu_insn_rem(malu_insn_rem), .malu_insn_macc(malu_insn_macc), .malu_insn_madd(malu_insn_madd),
    .malu_insn_msub(malu_insn_msub), .malu_pw(malu_pw), .malu_lhs_sign(malu_lhs_sign),
    .malu_rhs_sign(malu_rhs_sign), .malu_drem_unsigned(malu_drem_unsigned),
    .malu_carryless(malu_carryless), .malu_result_1(malu_result_1), .malu_result_0(malu_result_0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_err(rsp_err), .rsp_cycles(rsp_cycles), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [2:0] cur_cls, cur_pw;
  logic cur_ls, cur_rs, cur_uns, cur_clm, cur_err;
  logic [31:0] cur_a, cur_b, cur_c;
  logic [4:0] cur_rd;
  int cur_cycles;

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_result(input logic [2:0] cls, input logic ls, input logic rs,
                                             input logic uns, input logic clm,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
    logic [63:0] ea, eb, r;
    logic [31:0] q;
    if (cls == 3'd0) begin
      ea = ls ? {{32{a[31]}}, a} : {32'b0, a};
      eb = rs ? {{32{b[31]}}, b} : {32'b0, b};
      r = ea * eb;
      if (clm) r[31:0] = r[31:0] ^ 32'hA5A5A5A5;
    end else if (cls == 3'd2 || cls == 3'd3) begin
      if (b == 32'd0) begin
        q = (cls == 3'd2) ? 32'hFFFFFFFF : a;
      end else if (uns) begin
        q = (cls == 3'd2) ? a / b : a % b;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        q = (cls == 3'd2) ? 32'h80000000 : 32'd0;
      end else begin
        q = (cls == 3'd2) ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
      end
      r = {32'd0, q};
    end else begin
      // Stand-in behaviour for classes whose arithmetic the bench does not model.
      r = {c ^ {29'd0, cls}, a + b};
      if (clm && cls == 3'd1) r[31:0] = r[31:0] ^ 32'hA5A5A5A5;
    end
    return r;
  endfunction

  function automatic logic ref_err(input logic [2:0] cls, input logic [2:0] pw);
    return (cls == 3'd7) || (cls == 3'd1 && pw > 3'd4);
  endfunction

  function automatic logic [4:0] ref_pw(input logic [2:0] cls, input logic [2:0] pw);
    logic [4:0] top_bit;
    top_bit = 5'b10000;
    if (cls != 3'd1) return 5'b00001;
    return top_bit >> pw;
  endfunction

  // Malu stand-in: computes from what the DUT actually presents.
  function automatic logic [63:0] malu_model();
    logic [6:0] v;
    logic [2:0] cls;
    v = {malu_insn_msub, malu_insn_madd, malu_insn_macc, malu_insn_rem,
         malu_insn_div, malu_insn_pmul, malu_insn_mul};
    cls = 3'd7;
    for (int k = 0; k < 7; k++) if (v[k]) cls = 3'(k);
    return ref_result(cls, malu_lhs_sign, malu_rhs_sign, malu_drem_unsigned, malu_carryless,
                      malu_rs1, malu_rs2, malu_rs3);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [2:0] cls, input logic [2:0] pw, input logic ls,
                           input logic rs, input logic uns, input logic clm,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [4:0] rd);
    logic [63:0] r;
    req_class = cls; req_pw = pw; req_lhs_sign = ls; req_rhs_sign = rs;
    req_unsigned = uns; req_clmul = clm; req_rs1 = a; req_rs2 = b; req_rs3 = c; req_rd = rd;
    cur_cls = cls; cur_pw = pw; cur_ls = ls; cur_rs = rs; cur_uns = uns; cur_clm = clm;
    cur_a = a; cur_b = b; cur_c = c; cur_rd = rd;
    cur_err = ref_err(cls, pw);
    r = cur_err ? 64'd0 : ref_result(cls, ls, rs, uns, clm, a, b, c);
    exp_q.push_back({cur_err, rd, r});
    req_valid = 1'b1;
  endtask

  // Expects the request to be taken on the coming edge; returns at the next negedge.
  task automatic wait_accept(input string name);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: req_ready=%b expected 1", name, req_ready);
    end
    @(negedge clock);
    req_valid = 1'b0;
    // Scramble the request bus so only latched values can match.
    req_rs1 = $urandom; req_rs2 = $urandom; req_rs3 = $urandom;
    req_class = 3'($urandom_range(0, 7)); req_pw = 3'($urandom_range(0, 7));
    req_clmul = 1'($urandom_range(0, 1));
  endtask

  // Plays the malu for delay+1 RUN cycles; ready on the last one.
  task automatic run_phase(input int delay);
    int flushes;
    logic [63:0] r;
    logic [6:0] ei;
    logic [15:0] exp_dec, got_dec;
    flushes = 0;
    if (cur_err) begin
      cur_cycles = 0;
      #1;
      checks++;
      if (malu_valid !== 1'b0 || rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL err_bypass: malu_valid=%b rsp_valid=%b expected 0/1", malu_valid, rsp_valid);
      end
      return;
    end
    for (int k = 0; k < 7; k++) ei[k] = (cur_cls == 3'(k));
    exp_dec = {ei, ref_pw(cur_cls, cur_pw), cur_clm && (cur_cls == 3'd0 || cur_cls == 3'd1),
               cur_ls, cur_rs, cur_uns};
    for (int i = 0; i <= delay; i++) begin
      malu_ready = (i == delay);
      r = (i == delay) ? malu_model() : {$urandom, $urandom};
      {malu_result_1, malu_result_0} = r;
      #1;
      got_dec = {malu_insn_msub, malu_insn_madd, malu_insn_macc, malu_insn_rem, malu_insn_div,
                 malu_insn_pmul, malu_insn_mul, malu_pw, malu_carryless, malu_lhs_sign,
                 malu_rhs_sign, malu_drem_unsigned};
      checks++;
      if (malu_valid !== 1'b1 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL run_valid cyc%0d: malu_valid=%b rsp_valid=%b expected 1/0", i, malu_valid, rsp_valid);
      end
      checks++;
      if ({malu_rs1, malu_rs2, malu_rs3} !== {cur_a, cur_b, cur_c}) begin
        errors++;
        $display("FAIL run_operands cyc%0d: got %h %h %h expected %h %h %h", i,
                 malu_rs1, malu_rs2, malu_rs3, cur_a, cur_b, cur_c);
      end
      checks++;
      if (got_dec !== exp_dec) begin
        errors++;
        $display("FAIL run_decode cyc%0d: got %h expected %h", i, got_dec, exp_dec);
      end
      if (malu_flush === 1'b1) flushes++;
      @(negedge clock);
    end
    malu_ready = 1'b0;
    checks++;
    if (flushes != 1) begin
      errors++;
      $display("FAIL flush_count: got %0d expected 1", flushes);
    end
    cur_cycles = (delay + 1 > 255) ? 255 : delay + 1;
  endtask

  // Checks the held response for hold+1 cycles; completes the handshake unless b2b.
  task automatic resp_phase(input int hold, input bit b2b);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL resp_queue: got empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_err, rsp_rd, rsp_hi, rsp_lo, rsp_cycles} !== {1'b1, e, CYCLE_W'(cur_cycles)}) begin
        errors++;
        $display("FAIL resp cyc%0d: got v=%b err=%b rd=%0d %h_%h cyc=%0d expected v=1 err=%b rd=%0d %h_%h cyc=%0d",
                 i, rsp_valid, rsp_err, rsp_rd, rsp_hi, rsp_lo, rsp_cycles,
                 e[69], e[68:64], e[63:32], e[31:0], cur_cycles);
      end
      checks++;
      if (malu_flush !== 1'b0 || malu_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_quiet cyc%0d: flush=%b valid=%b expected 0/0", i, malu_flush, malu_valid);
      end
      if (i < hold) @(negedge clock);
    end
    if (!b2b) begin
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL resp_release: rsp_valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready);
      end
      @(negedge clock);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b0; kill = 1'b0; req_valid = 1'b1; rsp_ready = 1'b0; malu_ready = 1'b0;
    req_class = 3'd0; req_pw = 3'd0; req_lhs_sign = 0; req_rhs_sign = 0; req_unsigned = 0;
    req_clmul = 0; req_rs1 = 32'h1234; req_rs2 = 32'h5678; req_rs3 = 0; req_rd = 5'd1;
    malu_result_1 = 0; malu_result_0 = 0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({req_ready, malu_valid, malu_flush, rsp_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0000", {req_ready, malu_valid, malu_flush, rsp_valid});
    end
    checks++;
    if ({malu_rs1, malu_rs2, malu_rs3, malu_pw, rsp_rd, rsp_hi, rsp_lo, rsp_err, rsp_cycles} !== '0) begin
      errors++;
      $display("FAIL reset_regs: registered outputs not all zero");
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    req_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b expected 1", req_ready);
    end
    @(negedge clock);
  endtask

  task automatic test_mul_directed();
    drive_req(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 32'd0, 5'd3);
    wait_accept("mul_accept");
    run_phase(3);
    #1;
    checks++;
    if ({rsp_hi, rsp_lo, rsp_rd, rsp_err} !== {32'h00000001, 32'hFFFFFFFE, 5'd3, 1'b0}) begin
      errors++;
      $display("FAIL mul_const: got %h_%h rd=%0d err=%b expected 00000001_fffffffe rd=3 err=0",
               rsp_hi, rsp_lo, rsp_rd, rsp_err);
    end
    resp_phase(0, 1'b0);
  endtask

  task automatic test_div_rem();
    drive_req(3'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 32'd0, 5'd4);
    wait_accept("div_accept");
    run_phase(1);
    #1;
    checks++;
    if ({rsp_hi, rsp_lo} !== {32'd0, 32'hFFFFFFFF}) begin
      errors++;
      $display("FAIL div0_const: got %h_%h expected 00000000_ffffffff", rsp_hi, rsp_lo);
    end
    resp_phase(1, 1'b0);
    drive_req(3'd3, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2, 32'd0, 5'd5);
    wait_accept("rem_accept");
    run_phase(2);
    #1;
    checks++;
    if (rsp_lo !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL rem_const: got %h expected ffffffff", rsp_lo);
    end
    resp_phase(0, 1'b0);
  endtask

  task automatic test_decode();
    drive_req(3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0F0F0F0F, 32'h00FF00FF, 32'h3, 5'd6);
    wait_accept("pmul_accept");
    #1;
    checks++;
    if ({malu_pw, malu_carryless, malu_insn_pmul} !== {5'b01000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pmul_decode: pw=%b cl=%b pmul=%b expected 01000/1/1", malu_pw, malu_carryless, malu_insn_pmul);
    end
    run_phase(1);
    resp_phase(0, 1'b0);
    drive_req(3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 32'd0, 5'd7);
    wait_accept("divcl_accept");
    #1;
    checks++;
    if (malu_carryless !== 1'b0 || malu_pw !== 5'b00001) begin
      errors++;
      $display("FAIL div_clmul: carryless=%b pw=%b expected 0/00001", malu_carryless, malu_pw);
    end
    run_phase(0);
    resp_phase(0, 1'b0);
  endtask

  task automatic test_kill();
    drive_req(3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd11, 32'd13, 32'd0, 5'd8);
    wait_accept("kill_accept");
    repeat (2) @(negedge clock);  // RUN cycles 1 and 2
    kill = 1'b1;
    malu_ready = 1'b1;             // kill must win over completion
    #1;
    checks++;
    if ({malu_flush, malu_valid, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL kill_cycle: flush/valid/rsp=%b expected 100", {malu_flush, malu_valid, rsp_valid});
    end
    @(negedge clock);
    kill = 1'b0;
    malu_ready = 1'b0;
    #1;
    checks++;
    if ({malu_flush, malu_valid, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL kill_flsh: flush/valid/rsp=%b expected 100", {malu_flush, malu_valid, rsp_valid});
    end
    @(negedge clock);
    #1;
    checks++;
    if ({req_ready, malu_flush, malu_valid, rsp_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL kill_idle: rdy/flush/valid/rsp=%b expected 1000",
               {req_ready, malu_flush, malu_valid, rsp_valid});
    end
    exp_q.delete(exp_q.size() - 1);
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    drive_req(3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 32'd3, 32'd0, 5'd9);
    wait_accept("b2b_first");
    run_phase(2);
    resp_phase(5, 1'b1);
    drive_req(3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1000, 32'd33, 32'd0, 5'd10);
    rsp_ready = 1'b1;
    wait_accept("b2b_second");
    rsp_ready = 1'b0;
    run_phase(1);
    resp_phase(0, 1'b0);
  endtask

  task automatic test_error();
    drive_req(3'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd6, 32'd7, 5'd11);
    wait_accept("rsv_accept");
    run_phase(0);
    resp_phase(2, 1'b0);
    drive_req(3'd1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 32'd6, 32'd7, 5'd12);
    wait_accept("badpw_accept");
    run_phase(0);
    resp_phase(0, 1'b0);
  endtask

  task automatic test_saturate();
    drive_req(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 5'd13);
    wait_accept("sat_accept");
    run_phase(299);
    #1;
    checks++;
    if (rsp_cycles !== 8'd255) begin
      errors++;
      $display("FAIL sat_cycles: got %0d expected 255", rsp_cycles);
    end
    resp_phase(0, 1'b0);
  endtask

  task automatic test_mid_reset();
    drive_req(3'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd50, 32'd5, 32'd0, 5'd14);
    wait_accept("mrst_accept");
    @(negedge clock);
    resetn = 1'b0;
    #1;
    checks++;
    if ({malu_flush, malu_valid, req_ready} !== 3'b000) begin
      errors++;
      $display("FAIL mrst_strobes: flush/valid/rdy=%b expected 000", {malu_flush, malu_valid, req_ready});
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
    checks++;
    if ({req_ready, rsp_valid, malu_flush, malu_rs1, malu_rs2} !== {3'b100, 64'd0}) begin
      errors++;
      $display("FAIL mrst_idle: rdy=%b rsp=%b flush=%b rs1=%h rs2=%h expected 1/0/0/0/0",
               req_ready, rsp_valid, malu_flush, malu_rs1, malu_rs2);
    end
    exp_q.delete(exp_q.size() - 1);
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [31:0] corners[4];
    logic [31:0] ops[3];
    corners[0] = 32'd0; corners[1] = 32'hFFFFFFFF; corners[2] = 32'h80000000; corners[3] = 32'd1;
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 3; j++)
        ops[j] = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      drive_req(3'($urandom_range(0, 7)), 3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ops[0], ops[1], ops[2], 5'($urandom_range(0, 31)));
      wait_accept("rand_accept");
      run_phase($urandom_range(0, 6));
      resp_phase($urandom_range(0, 3), 1'b0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mul_directed();
    test_div_rem();
    test_decode();
    test_kill();
    test_back_to_back();
    test_error();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
